divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (only 32 supported).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request a new division this cycle.
REQ-005 SHALL have port kill_i  input  1  squash the in-flight operation (pipeline flush).
REQ-006 SHALL have port operation_i  input  RS5_pkg::iType_e  one of DIV, DIVU, REM, REMU; sampled with start_i.
REQ-007 SHALL have port rs1_data_i  input  32  dividend; sampled with start_i.
REQ-008 SHALL have port rs2_data_i  input  32  divisor; sampled with start_i.
REQ-009 SHALL have port hold_o  output  1  stall request to execute stage while unit is busy.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse: result_o valid this cycle.
REQ-011 SHALL have port result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-012 SHALL implement FSM with states D_IDLE, D_INIT, D_CALC, D_SIGN (RS5_pkg::div_states_e).
REQ-013 SHALL accept start_i only in D_IDLE; start_i in any other state is ignored.
REQ-014 SHALL transition D_IDLE -> D_INIT on accepted start; D_INIT latches operand magnitudes (signed ops: two's-complement absolute value) and the result sign flags.
REQ-015 SHALL run restoring division in D_CALC, one quotient bit per cycle, 32 cycles, using a 6-bit iteration counter cleared in D_INIT.
REQ-016 SHALL move D_CALC -> D_SIGN when counter reaches 31; D_SIGN -> D_IDLE unconditionally.
REQ-017 SHALL, in D_SIGN, drive result_o with sign-corrected value and assert done_o for exactly that cycle; full-path latency is 34 cycles (start at cycle 0, done_o at cycle 34).
REQ-018 SHALL negate quotient iff signed op, divisor nonzero and operand signs differ; negate remainder iff signed op and dividend negative.
REQ-019 SHALL give RISC-V M results: x/0 -> quotient 0xFFFFFFFF, remainder x; signed 0x80000000/-1 -> quotient 0x80000000, remainder 0.
REQ-020 SHALL drive hold_o = (D_IDLE and start_i and not kill_i) or state in {D_INIT, D_CALC}; deasserted in D_SIGN.
REQ-021 SHALL hold result_o at its last value between done_o pulses.
REQ-022 SHALL, on kill_i in any state, enter D_IDLE next cycle, suppress done_o, and leave result_o unchanged; kill_i wins over simultaneous start_i.
REQ-023 SHALL allow a new start_i in the D_IDLE cycle immediately following D_SIGN (back-to-back, no bubble beyond D_SIGN).

Reset
REQ-024 SHALL on reset set state D_IDLE, counter 0, done_o 0, result_o 0, hold_o 0 (next cycle), internal operand registers 0.
REQ-025 SHALL abort any in-flight operation on reset with no done_o pulse; reset has priority over kill_i and start_i.

Configuration
REQ-026 SHALL support macro DIV_FASTPATH_EN: when defined, an accepted start with divisor 0 or signed overflow (0x80000000 / -1) goes D_IDLE -> D_SIGN directly, done_o at cycle 1, hold_o asserted only in the start cycle.
REQ-027 SHALL, without DIV_FASTPATH_EN, process those cases through the full 34-cycle path, producing identical result values per REQ-019.

Verification
REQ-028 SHALL cover DIV 100 / -7 -> done_o at cycle 34, result_o 0xFFFFFFF2 (-14); REM same operands -> 2.
REQ-029 SHALL cover DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; REMU -> 0xF.
REQ-030 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000; REM -> 0; done_o at cycle 1 with DIV_FASTPATH_EN, cycle 34 without.
REQ-031 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-032 SHALL cover kill_i at cycle 10 of a DIV -> D_IDLE at cycle 11, no done_o, result_o unchanged; then new start completes normally.
REQ-033 SHALL cover start_i asserted at cycle 5 mid-operation -> ignored; first op result and done_o timing unaffected; synchronous reset at cycle 20 -> all outputs 0, no done_o.

Source files
------------

// File: rtl/RS5_pkg.sv
// Shared operation and divider FSM state encodings.
package RS5_pkg;

    typedef enum logic [1:0] {
        DIV,
        DIVU,
        REM,
        REMU
    } iType_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_INIT,
        D_CALC,
        D_SIGN
    } div_states_e;

endpackage

// File: rtl/divider_unit.sv
// Iterative restoring divider for RISC-V M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FASTPATH_EN retires divide-by-zero and signed overflow in one cycle.
module divider_unit
    import RS5_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            kill_i,
    input  iType_e          operation_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            hold_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CNT_W = 6;

    div_states_e     state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic            is_signed;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;

    logic            start_signed;
    logic            start_rem;
    logic [XLEN:0]   partial;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] final_res;

    assign start_signed = (operation_i == DIV) || (operation_i == REM);
    assign start_rem    = (operation_i == REM) || (operation_i == REMU);

    assign hold_o = ((state == D_IDLE) && start_i && !kill_i)
                  || (state == D_INIT) || (state == D_CALC);

    // One restoring step; the final step also feeds the sign-corrected result.
    always_comb begin
        partial = {rem, quo[XLEN-1]};
        diff    = partial - {1'b0, dvs};
        if (!diff[XLEN]) begin
            step_rem = diff[XLEN-1:0];
            step_quo = {quo[XLEN-2:0], 1'b1};
        end else begin
            step_rem = partial[XLEN-1:0];
            step_quo = {quo[XLEN-2:0], 1'b0};
        end
        if (is_rem) begin
            final_res = neg_r ? (XLEN'(0) - step_rem) : step_rem;
        end else begin
            final_res = neg_q ? (XLEN'(0) - step_quo) : step_quo;
        end
    end

`ifdef DIV_FASTPATH_EN
    logic            fast_zero;
    logic            fast_ovf;
    logic [XLEN-1:0] fast_res;

    // Special cases whose results are fixed by the ISA without iterating.
    always_comb begin
        fast_zero = (rs2_data_i == '0);
        fast_ovf  = start_signed
                  && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                  && (rs2_data_i == '1);
        if (fast_zero) begin
            fast_res = start_rem ? rs1_data_i : '1;
        end else begin
            fast_res = start_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= D_IDLE;
            count     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            is_signed <= 1'b0;
            is_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
        end else if (kill_i) begin
            state  <= D_IDLE;
            done_o <= 1'b0;
        end else begin
            case (state)
                D_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op_a      <= rs1_data_i;
                        op_b      <= rs2_data_i;
                        is_signed <= start_signed;
                        is_rem    <= start_rem;
`ifdef DIV_FASTPATH_EN
                        if (fast_zero || fast_ovf) begin
                            state    <= D_SIGN;
                            result_o <= fast_res;
                            done_o   <= 1'b1;
                        end else begin
                            state <= D_INIT;
                        end
`else
                        state <= D_INIT;
`endif
                    end
                end
                D_INIT: begin
                    quo   <= (is_signed && op_a[XLEN-1]) ? (XLEN'(0) - op_a) : op_a;
                    dvs   <= (is_signed && op_b[XLEN-1]) ? (XLEN'(0) - op_b) : op_b;
                    rem   <= '0;
                    count <= '0;
                    neg_q <= is_signed && (op_b != '0) && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                    neg_r <= is_signed && op_a[XLEN-1];
                    state <= D_CALC;
                end
                D_CALC: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(XLEN - 1)) begin
                        state    <= D_SIGN;
                        result_o <= final_res;
                        done_o   <= 1'b1;
                    end
                end
                D_SIGN: begin
                    done_o <= 1'b0;
                    state  <= D_IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit; build with or without DIV_FASTPATH_EN.
module tb_divider_unit;
    import RS5_pkg::*;

`ifdef DIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        kill_i;
    iType_e      operation_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        hold_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;

    divider_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .kill_i      (kill_i),
        .operation_i (operation_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .hold_o      (hold_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; returns just after the accepting edge (cycle 1).
    task automatic start_op(input iType_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operation_i = op;
        rs1_data_i  = a;
        rs2_data_i  = b;
        start_i     = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Full transaction; poke_cyc > 0 raises a stray start_i during that cycle.
    task automatic run_op(input string tag, input iType_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int poke_cyc);
        int cyc;
        @(negedge clk);
        operation_i = op;
        rs1_data_i  = a;
        rs2_data_i  = b;
        start_i     = 1'b1;
        #1 check({tag, " hold_start"}, 32'(hold_o), 32'd1);
        @(posedge clk);
        #1 start_i = 1'b0;
        cyc = 1;
        while (!done_o && cyc < 100) begin
            if (cyc == poke_cyc) begin
                start_i     = 1'b1;
                operation_i = DIVU;
                rs1_data_i  = 32'd9;
                rs2_data_i  = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk);
            #1 cyc++;
        end
        start_i = 1'b0;
        check({tag, " done_seen"}, 32'(done_o), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " result"}, result_o, exp);
        check({tag, " hold_sign"}, 32'(hold_o), 32'd0);
        @(posedge clk);
        #1 check({tag, " done_pulse"}, 32'(done_o), 32'd0);
        check({tag, " result_held"}, result_o, exp);
    endtask

    initial begin
        int cyc;
        int pulses;
        reset       = 1'b1;
        start_i     = 1'b0;
        kill_i      = 1'b0;
        operation_i = DIV;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset done", 32'(done_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset hold", 32'(hold_o), 32'd0);

        run_op("div 100/-7 poke5", DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, FULL_LAT, 5);
        run_op("rem 100/-7", REM, 32'd100, 32'hFFFF_FFF9, 32'd2, FULL_LAT, 0);
        run_op("divu ffffffff/16", DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, FULL_LAT, 0);
        run_op("remu ffffffff/16", REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, FULL_LAT, 0);
        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, 0);
        run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPECIAL_LAT, 0);
        run_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
        run_op("remu 5/0", REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT, 0);
        run_op("div -100/7", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, FULL_LAT, 0);
        run_op("rem -100/7", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, FULL_LAT, 0);
        run_op("rem -7/0", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPECIAL_LAT, 0);

        // Kill during cycle 10: idle at cycle 11, no pulse, result untouched.
        start_op(DIV, 32'd1000, 32'd3);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        check("kill idle_hold", 32'(hold_o), 32'd0);
        check("kill result", result_o, 32'hFFFF_FFF9);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done_o) pulses++;
        end
        check("kill no_done", 32'(pulses), 32'd0);
        check("kill result_late", result_o, 32'hFFFF_FFF9);
        run_op("divu 1000/3", DIVU, 32'd1000, 32'd3, 32'd333, FULL_LAT, 0);

        // Synchronous reset during cycle 20 aborts the operation.
        start_op(DIV, 32'd77, 32'd5);
        cyc = 1;
        while (cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst done", 32'(done_o), 32'd0);
        check("rst result", result_o, 32'd0);
        check("rst hold", 32'(hold_o), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done_o) pulses++;
        end
        check("rst no_done", 32'(pulses), 32'd0);
        run_op("divu 12/4", DIVU, 32'd12, 32'd4, 32'd3, FULL_LAT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
